// File: rtl/seg_scan_if.sv
// seg_scan_if: bundle between the clock core and the display scanner.
//   SecLoSeg/SecHiSeg/MinLoSeg/MinHiSeg : 7-seg patterns, active-low, bit0=a..bit6=g
//   brightness : on-time in eighths of a digit slot (0=off, 7=max)
//   seg_out    : shared segment bus, active-low
//   dig_en     : digit enables, active-low
//   colon      : colon LED, active-high
// master = pattern source / pin consumer, slave = scanner.
interface seg_scan_if;
  logic [6:0] SecLoSeg;
  logic [6:0] SecHiSeg;
  logic [6:0] MinLoSeg;
  logic [6:0] MinHiSeg;
  logic [2:0] brightness;
  logic [6:0] seg_out;
  logic [3:0] dig_en;
  logic       colon;

  modport master (
    output SecLoSeg, SecHiSeg, MinLoSeg, MinHiSeg, brightness,
    input  seg_out, dig_en, colon
  );

  modport slave (
    input  SecLoSeg, SecHiSeg, MinLoSeg, MinHiSeg, brightness,
    output seg_out, dig_en, colon
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes four 7-seg patterns onto a common-anode
// 4-digit display. Frame-start snapshot of all digits (no tearing), a dark
// first eighth of every slot (anti-ghosting), 8-level PWM brightness and a
// free-running blinking colon.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seg_scan_if.slave (patterns + brightness in, seg_out/dig_en/colon out)
module seg_scan_mux #(
  parameter int CLK_HZ     = 50000000,
  parameter int FRAME_HZ   = 1000,
  parameter int COLON_HALF = CLK_HZ / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);
  localparam int SLOT   = CLK_HZ / (4 * FRAME_HZ);
  localparam int PH_LEN = SLOT / 8;
  localparam int SW     = $clog2(SLOT);
  localparam int CW     = $clog2(COLON_HALF + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT - 1);
  localparam logic [CW-1:0] COLON_LAST = CW'(COLON_HALF - 1);

  logic [SW-1:0]     slot_cnt_q, slot_cnt_d;
  logic [1:0]        dig_idx_q, dig_idx_d;
  logic [CW-1:0]     colon_cnt_q, colon_cnt_d;
  logic [3:0][6:0]   shadow_q, shadow_d;
  logic [2:0]        bri_q, bri_d;
  logic [6:0]        seg_out_q, seg_out_d;
  logic [3:0]        dig_en_q, dig_en_d;
  logic              colon_q, colon_d;
  logic [SW-1:0]     phase;
  logic              lit;

  // Phase 0 is always dark; phases 1..bri_q are lit.
  assign phase = slot_cnt_q / SW'(PH_LEN);
  assign lit   = (phase != '0) && (phase <= SW'(bri_q));

  always_comb begin
    slot_cnt_d  = slot_cnt_q + 1'b1;
    dig_idx_d   = dig_idx_q;
    colon_cnt_d = colon_cnt_q + 1'b1;
    colon_d     = colon_q;
    shadow_d    = shadow_q;
    bri_d       = bri_q;
    seg_out_d   = 7'h7F;
    dig_en_d    = 4'hF;

    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 1'b1;
    end

    if (colon_cnt_q == COLON_LAST) begin
      colon_cnt_d = '0;
      colon_d     = ~colon_q;
    end

    if (slot_cnt_q == '0) begin
      bri_d = bus.brightness;
      if (dig_idx_q == 2'd0) begin
        shadow_d[0] = bus.SecLoSeg;
        shadow_d[1] = bus.SecHiSeg;
        shadow_d[2] = bus.MinLoSeg;
        shadow_d[3] = bus.MinHiSeg;
      end
    end

    // Capture edge coincides with phase 0, so the current shadow is safe here.
    if (lit) begin
      seg_out_d = shadow_q[dig_idx_q];
      dig_en_d  = ~(4'b0001 << dig_idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      dig_idx_q   <= '0;
      colon_cnt_q <= '0;
      colon_q     <= 1'b0;
      shadow_q    <= {4{7'h7F}};
      bri_q       <= '0;
      seg_out_q   <= 7'h7F;
      dig_en_q    <= 4'hF;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      dig_idx_q   <= dig_idx_d;
      colon_cnt_q <= colon_cnt_d;
      colon_q     <= colon_d;
      shadow_q    <= shadow_d;
      bri_q       <= bri_d;
      seg_out_q   <= seg_out_d;
      dig_en_q    <= dig_en_d;
    end
  end

  assign bus.seg_out = seg_out_q;
  assign bus.dig_en  = dig_en_q;
  assign bus.colon   = colon_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux at CLK_HZ=3200, FRAME_HZ=25 (32-cycle slots,
// 4-cycle phases), COLON_HALF=40. The reference model derives every output
// from the number of clock edges since reset release (k) plus the inputs
// seen at the relevant capture edges.
module tb_seg_scan_mux;
  localparam int SLOT = 32;
  localparam int PH   = 4;
  localparam int FRM  = 4 * SLOT;
  localparam int CH   = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  seg_scan_if bus ();

  seg_scan_mux #(.CLK_HZ(3200), .FRAME_HZ(25), .COLON_HALF(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int         mk = 0;
  logic [6:0] m_shadow [4];
  int         m_bri = 0;
  logic [6:0] exp_seg;
  logic [3:0] exp_dig;
  logic       exp_colon;

  // Applies one clock edge with the currently driven inputs and checks outputs.
  task automatic cyc();
    int sc, dig, phase;
    logic is_lit;
    if (!rst_n) begin
      mk = 0;
      m_bri = 0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 7'h7F;
      exp_seg = 7'h7F; exp_dig = 4'hF; exp_colon = 1'b0;
    end else begin
      sc    = mk % SLOT;
      dig   = (mk / SLOT) % 4;
      phase = sc / PH;
      is_lit = (phase >= 1) && (phase <= m_bri);
      exp_seg   = is_lit ? m_shadow[dig] : 7'h7F;
      exp_dig   = is_lit ? ~(4'(1) << dig) : 4'hF;
      exp_colon = (((mk + 1) / CH) % 2) == 1;
      if (sc == 0) m_bri = int'(bus.brightness);
      if (mk % FRM == 0) begin
        m_shadow[0] = bus.SecLoSeg; m_shadow[1] = bus.SecHiSeg;
        m_shadow[2] = bus.MinLoSeg; m_shadow[3] = bus.MinHiSeg;
      end
      mk++;
    end
    @(posedge clk);
    #1;
    vectors++;
    assert (bus.seg_out === exp_seg) else begin
      miscompares++;
      $error("FAIL seg_out k=%0d got=%h exp=%h", mk, bus.seg_out, exp_seg);
    end
    assert (bus.dig_en === exp_dig) else begin
      miscompares++;
      $error("FAIL dig_en k=%0d got=%h exp=%h", mk, bus.dig_en, exp_dig);
    end
    assert (bus.colon === exp_colon) else begin
      miscompares++;
      $error("FAIL colon k=%0d got=%b exp=%b", mk, bus.colon, exp_colon);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_segs(input logic [6:0] a, b, c, d);
    bus.SecLoSeg = a; bus.SecHiSeg = b; bus.MinLoSeg = c; bus.MinHiSeg = d;
  endtask

  int lit_cnt;

  initial begin
    set_segs(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
    bus.brightness = 3'($urandom);

    // reset held 3 cycles, arbitrary inputs
    rst_n = 1'b0;
    run(3);

    // scan order at full brightness
    set_segs(7'h40, 7'h79, 7'h24, 7'h30);
    bus.brightness = 3'd7;
    rst_n = 1'b1;
    run(FRM + 8);

    // count lit cycles of one slot as a directed cross-check: 28 of 32
    while (mk % SLOT != 0) cyc();
    lit_cnt = 0;
    for (int i = 0; i < SLOT; i++) begin
      cyc();
      if (bus.dig_en != 4'hF) lit_cnt++;
    end
    vectors++;
    assert (lit_cnt == 28) else begin
      miscompares++;
      $error("FAIL lit_count_b7 got=%0d exp=28", lit_cnt);
    end

    // brightness 0 for two full frames
    bus.brightness = 3'd0;
    run(2 * FRM + 4);

    // brightness 3, then 3->7 at slot_cnt=10
    bus.brightness = 3'd3;
    run(FRM);
    while (mk % SLOT != 10) cyc();
    bus.brightness = 3'd7;
    run(2 * SLOT);

    // no tearing: change SecHi while digit 2 is scanning
    while ((mk % FRM) != 2 * SLOT + 5) cyc();
    bus.SecHiSeg = 7'h12;
    run(FRM + SLOT * 2);

    // random patterns and brightness changing at random points
    for (int r = 0; r < 60; r++) begin
      set_segs(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
      bus.brightness = 3'($urandom);
      run($urandom_range(1, 40));
    end

    // reset mid-scan at dig_idx=2, phase=3
    while ((mk % FRM) != 2 * SLOT + 3 * PH) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set_segs(7'h06, 7'h5B, 7'h4F, 7'h66);
    bus.brightness = 3'd5;
    run(2 * FRM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Downstream display stage for the clock core. Takes the four 7-segment patterns (seconds low/high, minutes low/high) and time-multiplexes them onto a shared common-anode 4-digit display with one segment bus and four digit enables. Adds tear-free frame snapshotting, per-digit dead time, 8-level brightness PWM and a 1 Hz blinking colon. Sits between the clock core and the board pins.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
FRAME_HZ, 1000, full 4-digit refresh rate in Hz; SLOT = CLK_HZ/(4*FRAME_HZ) cycles per digit; SLOT must be a multiple of 8 and >= 8
COLON_HALF, CLK_HZ/2, cycles per colon half-period

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous, active-low reset
SecLoSeg  in  7  segment pattern, seconds units, active-low, bit0=a..bit6=g
SecHiSeg  in  7  segment pattern, seconds tens
MinLoSeg  in  7  segment pattern, minutes units
MinHiSeg  in  7  segment pattern, minutes tens
brightness  in  3  on-time in eighths of a slot, 0=off, 7=max
seg_out  out  7  shared segment bus, active-low
dig_en  out  4  digit enables, active-low, one-hot-low or all high
colon  out  1  colon LED, active-high

Behaviour:
- Reset (rst_n=0 at a clk edge): slot_cnt=0, dig_idx=0, colon_cnt=0; shadow regs = 7'h7F; seg_out=7'h7F, dig_en=4'hF, colon=0. Reset mid-scan aborts the frame; outputs blank at that edge.
- slot_cnt counts 0..SLOT-1, wraps to 0; on wrap dig_idx increments 0->1->2->3->0.
- Digit map: dig_idx 0=SecLo (dig_en[0]), 1=SecHi, 2=MinLo, 3=MinHi (dig_en[3]).
- Snapshot: when slot_cnt==0 and dig_idx==0, all four inputs are captured into shadow regs in the same edge. Display uses only shadow values; input changes mid-frame never show until the next frame start.
- brightness captured into bri_q when slot_cnt==0 (every slot); mid-slot changes take effect next slot.
- phase = slot_cnt / (SLOT/8), range 0..7. Digit lit when 1 <= phase <= bri_q. Phase 0 is always dark (anti-ghosting dead time). bri_q=0: digit never lit; bri_q=7: lit for 7/8 of slot.
- Outputs registered: seg_out/dig_en reflect the counter state of the previous cycle (1-cycle latency). When lit: dig_en = ~(4'b0001 << dig_idx), seg_out = shadow[dig_idx]. When dark: dig_en=4'hF, seg_out=7'h7F. seg_out and dig_en always change on the same edge.
- Colon: colon_cnt counts 0..COLON_HALF-1; on wrap colon toggles. First toggle to 1 occurs COLON_HALF cycles after reset release. Colon is not affected by brightness.
- Input-to-display latency: capture at frame start; first lit cycle for digit 0 is SLOT/8+1 cycles after capture (bri_q>=1).
- All counters wrap silently; no overflow states.

Test Plan:
Sim params CLK_HZ=3200, FRAME_HZ=25 (SLOT=32, phase length 4), COLON_HALF=40.
- Reset: hold rst_n=0 for 3 cycles, inputs arbitrary -> seg_out=7'h7F, dig_en=4'hF, colon=0 throughout and on first cycle after release.
- Scan order: SecLo=7'h40, SecHi=7'h79, MinLo=7'h24, MinHi=7'h30, brightness=7 -> dig_en cycles E,D,B,7 each lit 28 of 32 cycles with the matching pattern; 4 dark cycles (F/7F) before each digit.
- Brightness: brightness=0 -> dig_en stays F for 2 full frames; brightness=3 -> each digit lit exactly 12 consecutive cycles per slot; change brightness 3->7 at slot_cnt=10 -> current slot still 12 lit, next slot 28 lit.
- No tearing: change SecHiSeg 7'h79->7'h12 while dig_idx=2 -> remaining frame shows 7'h79; new value shows in slot 1 of the next frame only.
- Colon: after reset release colon rises at cycle 40, falls at 80, rises at 120, independent of brightness=0.
- Reset mid-scan: assert rst_n=0 for one cycle while dig_idx=2, phase=3 -> outputs blank at that edge; after release scanning restarts at dig_idx=0 with shadow=7'h7F until the frame-start capture.
